// File: rtl/spi_dac_seq.sv
// Multi-channel SPI DAC writer: latches one sample per channel and sends one {cmd,data}
// frame per enabled channel, each under its own nCS, then an optional shared nLDAC strobe.
module spi_dac_seq #(
    parameter int NCH     = 2,
    parameter int DATA_W  = 12,
    parameter int CMD_W   = 4,
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 2,
    parameter int LDAC_EN = 1,
    parameter int LDAC_W  = 2
) (
    input  logic                    ICLK,
    input  logic                    RST,
    input  logic [NCH*DATA_W-1:0]   DAT,
    input  logic [NCH*CMD_W-1:0]    CMD,
    input  logic [NCH-1:0]          CH_EN,
    input  logic                    VALID,
    output logic                    READY,
    output logic                    SCK,
    output logic                    nCS,
    output logic                    SDI,
    output logic                    nLDAC,
    output logic                    BUSY
);

    localparam int FRAME_W = CMD_W + DATA_W;
    localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1;
    // One extra index bit so "no channel left" (== NCH) never aliases channel 0
    localparam int IDX_W   = CH_W + 1;
    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? ((CLK_DIV > LDAC_W) ? CLK_DIV : LDAC_W)
                                                : ((CS_GAP > LDAC_W) ? CS_GAP : LDAC_W);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(FRAME_W + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_GAP   = 3'd3,
        S_LDAC  = 3'd4,
        S_EMPTY = 3'd5
    } state_t;

    state_t                  state_r, state_s;
    logic [CNT_W-1:0]        cnt_r, cnt_s;
    logic [BIT_W-1:0]        bit_r, bit_s;
    logic [IDX_W-1:0]        ch_r, ch_s;
    logic [FRAME_W-1:0]      shreg_r, shreg_s;
    logic [NCH*DATA_W-1:0]   dat_r, dat_s;
    logic [NCH*CMD_W-1:0]    cmd_r, cmd_s;
    logic [NCH-1:0]          en_r, en_s;
    logic                    ready_r, ready_s;
    logic                    busy_r;
    logic                    sck_r, sck_s;
    logic                    ncs_r, ncs_s;
    logic                    sdi_r, sdi_s;
    logic                    nldac_r, nldac_s;

    logic [IDX_W-1:0]        first_idx_s, next_idx_s;
    logic [FRAME_W-1:0]      first_frame_s, next_frame_s;

    // Lowest enabled channel index at or above 'from'; NCH when none remains
    function automatic logic [IDX_W-1:0] find_en(input logic [NCH-1:0] en,
                                                 input logic [IDX_W-1:0] from);
        logic [IDX_W-1:0] r;
        r = IDX_W'(NCH);
        for (int i = NCH - 1; i >= 0; i--) begin
            r = (en[i] && (IDX_W'(i) >= from)) ? IDX_W'(i) : r;
        end
        return r;
    endfunction

    function automatic logic [FRAME_W-1:0] frame_of(input logic [NCH*DATA_W-1:0] dat,
                                                    input logic [NCH*CMD_W-1:0]  cmd,
                                                    input logic [IDX_W-1:0]      k);
        logic [FRAME_W-1:0] f;
        f = FRAME_W'(0);
        for (int i = 0; i < NCH; i++) begin
            f = (IDX_W'(i) == k) ? {cmd[i*CMD_W +: CMD_W], dat[i*DATA_W +: DATA_W]} : f;
        end
        return f;
    endfunction

    // The first frame is built straight from the inputs so SETUP starts on the accept edge
    assign first_idx_s   = find_en(CH_EN, IDX_W'(0));
    assign first_frame_s = frame_of(DAT, CMD, first_idx_s);
    assign next_idx_s    = find_en(en_r, ch_r + IDX_W'(1));
    assign next_frame_s  = frame_of(dat_r, cmd_r, next_idx_s);

    // Next-state and next-output logic for the frame sequencer
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        bit_s   = bit_r;
        ch_s    = ch_r;
        shreg_s = shreg_r;
        dat_s   = dat_r;
        cmd_s   = cmd_r;
        en_s    = en_r;
        ready_s = ready_r;
        sck_s   = sck_r;
        ncs_s   = ncs_r;
        sdi_s   = sdi_r;
        nldac_s = nldac_r;
        case (state_r)
            S_IDLE: begin
                if (VALID == 1'b1) begin
                    dat_s   = DAT;
                    cmd_s   = CMD;
                    en_s    = CH_EN;
                    ready_s = 1'b0;
                    cnt_s   = CNT_W'(0);
                    if (first_idx_s < IDX_W'(NCH)) begin
                        state_s = S_SETUP;
                        ch_s    = first_idx_s;
                        shreg_s = first_frame_s;
                        sdi_s   = first_frame_s[FRAME_W-1];
                        ncs_s   = 1'b0;
                    end else begin
                        state_s = S_EMPTY;
                    end
                end else begin
                    ready_s = 1'b1;
                end
            end
            S_SETUP: begin
                if (cnt_r == CNT_W'(CLK_DIV - 1)) begin
                    state_s = S_SHIFT;
                    cnt_s   = CNT_W'(0);
                    bit_s   = BIT_W'(0);
                    sck_s   = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            S_SHIFT: begin
                if (cnt_r != CNT_W'(CLK_DIV - 1)) begin
                    cnt_s = cnt_r + CNT_W'(1);
                end else begin
                    cnt_s = CNT_W'(0);
                    if (sck_r == 1'b1) begin
                        // Falling edge: present the next bit (zero after the last one)
                        sck_s   = 1'b0;
                        shreg_s = {shreg_r[FRAME_W-2:0], 1'b0};
                        sdi_s   = shreg_r[FRAME_W-2];
                    end else if (bit_r == BIT_W'(FRAME_W - 1)) begin
                        state_s = S_GAP;
                        ncs_s   = 1'b1;
                        sdi_s   = 1'b0;
                    end else begin
                        sck_s = 1'b1;
                        bit_s = bit_r + BIT_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (cnt_r != CNT_W'(CS_GAP - 1)) begin
                    cnt_s = cnt_r + CNT_W'(1);
                end else begin
                    cnt_s = CNT_W'(0);
                    if (next_idx_s < IDX_W'(NCH)) begin
                        state_s = S_SETUP;
                        ch_s    = next_idx_s;
                        shreg_s = next_frame_s;
                        sdi_s   = next_frame_s[FRAME_W-1];
                        ncs_s   = 1'b0;
                    end else if (LDAC_EN != 0) begin
                        state_s = S_LDAC;
                        nldac_s = 1'b0;
                    end else begin
                        state_s = S_IDLE;
                        ready_s = 1'b1;
                    end
                end
            end
            S_LDAC: begin
                if (cnt_r != CNT_W'(LDAC_W - 1)) begin
                    cnt_s = cnt_r + CNT_W'(1);
                end else begin
                    cnt_s   = CNT_W'(0);
                    nldac_s = 1'b1;
                    state_s = S_IDLE;
                    ready_s = 1'b1;
                end
            end
            S_EMPTY: begin
                state_s = S_IDLE;
                ready_s = 1'b1;
            end
            default: begin
                state_s = S_IDLE;
                ready_s = 1'b1;
                sck_s   = 1'b0;
                ncs_s   = 1'b1;
                sdi_s   = 1'b0;
                nldac_s = 1'b1;
            end
        endcase
    end

    // State, latched sample and registered pin drivers
    always_ff @(posedge ICLK or posedge RST) begin
        if (RST) begin
            state_r <= S_IDLE;
            cnt_r   <= CNT_W'(0);
            bit_r   <= BIT_W'(0);
            ch_r    <= IDX_W'(0);
            shreg_r <= FRAME_W'(0);
            dat_r   <= (NCH*DATA_W)'(0);
            cmd_r   <= (NCH*CMD_W)'(0);
            en_r    <= NCH'(0);
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            sck_r   <= 1'b0;
            ncs_r   <= 1'b1;
            sdi_r   <= 1'b0;
            nldac_r <= 1'b1;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            bit_r   <= bit_s;
            ch_r    <= ch_s;
            shreg_r <= shreg_s;
            dat_r   <= dat_s;
            cmd_r   <= cmd_s;
            en_r    <= en_s;
            ready_r <= ready_s;
            busy_r  <= ~ready_s;
            sck_r   <= sck_s;
            ncs_r   <= ncs_s;
            sdi_r   <= sdi_s;
            nldac_r <= nldac_s;
        end
    end

    assign READY = ready_r;
    assign BUSY  = busy_r;
    assign SCK   = sck_r;
    assign nCS   = ncs_r;
    assign SDI   = sdi_r;
    assign nLDAC = nldac_r;

endmodule

// File: tb/tb_spi_dac_seq.sv
// Directed bench for spi_dac_seq: a default 2-channel instance and a 4-channel,
// CLK_DIV=1, no-LDAC instance, observed by a pin-level SPI monitor.
module tb_spi_dac_seq;

    logic        ICLK;
    logic        RST;
    logic [23:0] DAT0;
    logic [7:0]  CMD0;
    logic [1:0]  EN0;
    logic        VALID0;
    logic [39:0] DAT1;
    logic [23:0] CMD1;
    logic [3:0]  EN1;
    logic        VALID1;
    logic [1:0]  ready_w, busy_w, sck_w, ncs_w, sdi_w, nldac_w;

    int n_chk  = 0;
    int n_fail = 0;

    spi_dac_seq u0 (
        .ICLK(ICLK), .RST(RST), .DAT(DAT0), .CMD(CMD0), .CH_EN(EN0), .VALID(VALID0),
        .READY(ready_w[0]), .SCK(sck_w[0]), .nCS(ncs_w[0]), .SDI(sdi_w[0]),
        .nLDAC(nldac_w[0]), .BUSY(busy_w[0])
    );

    spi_dac_seq #(.NCH(4), .DATA_W(10), .CMD_W(6), .CLK_DIV(1), .LDAC_EN(0)) u1 (
        .ICLK(ICLK), .RST(RST), .DAT(DAT1), .CMD(CMD1), .CH_EN(EN1), .VALID(VALID1),
        .READY(ready_w[1]), .SCK(sck_w[1]), .nCS(ncs_w[1]), .SDI(sdi_w[1]),
        .nLDAC(nldac_w[1]), .BUSY(busy_w[1])
    );

    initial ICLK = 1'b0;
    always #5 ICLK = ~ICLK;

    // Monitor records, per instance
    logic [15:0] frm_a [2][64];
    int          rise_a[2][64];
    int          csl_a [2][64];
    int          gap_a [2][64];
    int          ldw_a [2][64];
    int          bsy_a [2][64];
    int          nfrm[2], ngap[2], nldw[2], nbsy[2], ldlow_tot[2], sck_bad[2];
    logic [15:0] shv[2];
    int          rise_c[2], csl_c[2], hi_c[2], ldl_c[2], bsy_c[2];
    logic [1:0]  prev_sck, prev_ncs;

    // Pin-level monitor: captures SDI on SCK rises and measures nCS/nLDAC/BUSY widths
    always @(negedge ICLK) begin
        for (int g = 0; g < 2; g++) begin
            if (RST) begin
                shv[g]    <= 16'h0;
                rise_c[g] <= 0;
                csl_c[g]  <= 0;
                hi_c[g]   <= 0;
                ldl_c[g]  <= 0;
                bsy_c[g]  <= 0;
            end else begin
                if (ncs_w[g] == 1'b0) begin
                    csl_c[g] <= csl_c[g] + 1;
                    if (sck_w[g] && !prev_sck[g]) begin
                        shv[g]    <= {shv[g][14:0], sdi_w[g]};
                        rise_c[g] <= rise_c[g] + 1;
                    end
                    if (prev_ncs[g] && hi_c[g] > 0) begin
                        gap_a[g][ngap[g]] <= hi_c[g];
                        ngap[g]           <= ngap[g] + 1;
                    end
                    hi_c[g] <= 0;
                end else begin
                    if (prev_ncs[g] == 1'b0) begin
                        frm_a[g][nfrm[g]]  <= shv[g];
                        rise_a[g][nfrm[g]] <= rise_c[g];
                        csl_a[g][nfrm[g]]  <= csl_c[g];
                        nfrm[g]            <= nfrm[g] + 1;
                        shv[g]             <= 16'h0;
                        rise_c[g]          <= 0;
                        csl_c[g]           <= 0;
                    end
                    if (sck_w[g]) sck_bad[g] <= sck_bad[g] + 1;
                    hi_c[g] <= busy_w[g] ? hi_c[g] + 1 : 0;
                end
                if (nldac_w[g] == 1'b0) begin
                    ldl_c[g]     <= ldl_c[g] + 1;
                    ldlow_tot[g] <= ldlow_tot[g] + 1;
                end else if (ldl_c[g] > 0) begin
                    ldw_a[g][nldw[g]] <= ldl_c[g];
                    nldw[g]           <= nldw[g] + 1;
                    ldl_c[g]          <= 0;
                end
                if (busy_w[g]) begin
                    bsy_c[g] <= bsy_c[g] + 1;
                end else if (bsy_c[g] > 0) begin
                    bsy_a[g][nbsy[g]] <= bsy_c[g];
                    nbsy[g]           <= nbsy[g] + 1;
                    bsy_c[g]          <= 0;
                end
            end
            prev_sck[g] <= sck_w[g];
            prev_ncs[g] <= ncs_w[g];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input int g, input int maxc);
        int n;
        n = 0;
        while (ready_w[g] !== 1'b1 && n < maxc) begin
            @(negedge ICLK);
            n++;
        end
        if (ready_w[g] !== 1'b1) check("ready_timeout", {31'd0, ready_w[g]}, 32'd1);
    endtask

    task automatic send0(input logic [23:0] d, input logic [7:0] c, input logic [1:0] e);
        @(negedge ICLK);
        DAT0 = d; CMD0 = c; EN0 = e; VALID0 = 1'b1;
        @(negedge ICLK);
        VALID0 = 1'b0;
        wait_ready(0, 400);
        repeat (3) @(negedge ICLK);
    endtask

    task automatic send1(input logic [39:0] d, input logic [23:0] c, input logic [3:0] e);
        @(negedge ICLK);
        DAT1 = d; CMD1 = c; EN1 = e; VALID1 = 1'b1;
        @(negedge ICLK);
        VALID1 = 1'b0;
        wait_ready(1, 400);
        repeat (3) @(negedge ICLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bf, bg, bl, bb;
        RST = 1'b1;
        DAT0 = 24'h0; CMD0 = 8'h0; EN0 = 2'b00; VALID0 = 1'b0;
        DAT1 = 40'h0; CMD1 = 24'h0; EN1 = 4'h0; VALID1 = 1'b0;
        repeat (2) @(negedge ICLK);
        check("rst_outs_u0", {26'd0, ready_w[0], busy_w[0], sck_w[0], ncs_w[0], sdi_w[0], nldac_w[0]}, 32'b100101);
        check("rst_outs_u1", {26'd0, ready_w[1], busy_w[1], sck_w[1], ncs_w[1], sdi_w[1], nldac_w[1]}, 32'b100101);
        #2 RST = 1'b0;

        // Reset during bit 7 of frame 0
        @(negedge ICLK);
        DAT0 = 24'hABC123; CMD0 = 8'hB3; EN0 = 2'b11; VALID0 = 1'b1;
        @(negedge ICLK);
        VALID0 = 1'b0;
        repeat (30) @(negedge ICLK);
        check("prerst_sck", {31'd0, sck_w[0]}, 32'd1);
        check("prerst_ncs", {31'd0, ncs_w[0]}, 32'd0);
        #2 RST = 1'b1;
        #1 check("midrst_outs", {26'd0, ready_w[0], busy_w[0], sck_w[0], ncs_w[0], sdi_w[0], nldac_w[0]}, 32'b100101);
        @(negedge ICLK);
        #2 RST = 1'b0;
        repeat (2) @(negedge ICLK);
        check("midrst_no_frame", nfrm[0], 0);

        // Both channels, default parameters
        bf = nfrm[0]; bg = ngap[0]; bl = nldw[0]; bb = nbsy[0];
        send0(24'hABC123, 8'hB3, 2'b11);
        check("t2_nfrm",  nfrm[0] - bf, 2);
        check("t2_frm0",  {16'd0, frm_a[0][bf]}, 32'h3123);
        check("t2_frm1",  {16'd0, frm_a[0][bf+1]}, 32'hBABC);
        check("t2_rise0", rise_a[0][bf], 16);
        check("t2_rise1", rise_a[0][bf+1], 16);
        check("t2_csl0",  csl_a[0][bf], 66);
        check("t2_csl1",  csl_a[0][bf+1], 66);
        check("t2_gap",   gap_a[0][bg], 2);
        check("t2_ngap",  ngap[0] - bg, 1);
        check("t2_ldac",  ldw_a[0][bl], 2);
        check("t2_busy",  bsy_a[0][bb], 138);

        // Only channel 1 enabled, then no channel enabled
        bf = nfrm[0]; bg = ngap[0]; bl = nldw[0]; bb = nbsy[0];
        send0(24'hABC123, 8'hB3, 2'b10);
        check("t3_nfrm",  nfrm[0] - bf, 1);
        check("t3_frm",   {16'd0, frm_a[0][bf]}, 32'hBABC);
        check("t3_csl",   csl_a[0][bf], 66);
        check("t3_ngap",  ngap[0] - bg, 0);
        check("t3_ldac",  ldw_a[0][bl], 2);
        check("t3_busy",  bsy_a[0][bb], 70);
        bf = nfrm[0]; bl = nldw[0]; bb = nbsy[0];
        send0(24'hABC123, 8'hB3, 2'b00);
        check("t3e_nfrm", nfrm[0] - bf, 0);
        check("t3e_nldw", nldw[0] - bl, 0);
        check("t3e_busy", bsy_a[0][bb], 1);

        // VALID held high, DAT moves on after each accept and is scrambled while busy
        bf = nfrm[0]; bb = nbsy[0];
        @(negedge ICLK);
        CMD0 = 8'h57; EN0 = 2'b11; DAT0 = {12'h0A0, 12'h010}; VALID0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_ready(0, 400);
            @(posedge ICLK);
            #1;
            DAT0 = 24'($urandom);
            if (i == 2) VALID0 = 1'b0;
            if (i < 2) begin
                repeat (40) @(negedge ICLK);
                DAT0 = {12'h0A0 + 12'(i + 1), 12'h010 + 12'(i + 1)};
            end
        end
        @(negedge ICLK);
        wait_ready(0, 400);
        repeat (3) @(negedge ICLK);
        check("b2b_nfrm", nfrm[0] - bf, 6);
        check("b2b_nbsy", nbsy[0] - bb, 3);
        for (int i = 0; i < 3; i++) begin
            check("b2b_frm_ch0", {16'd0, frm_a[0][bf + 2*i]},     32'h7010 + 32'(i));
            check("b2b_frm_ch1", {16'd0, frm_a[0][bf + 2*i + 1]}, 32'h50A0 + 32'(i));
            check("b2b_busy",    bsy_a[0][bb + i], 138);
        end

        // Four channels, CLK_DIV=1, no nLDAC
        bf = nfrm[1]; bg = ngap[1]; bb = nbsy[1];
        send1({10'h3FF, 10'h2AA, 10'h155, 10'h001}, {6'h3F, 6'h2A, 6'h15, 6'h01}, 4'hF);
        check("t5_nfrm", nfrm[1] - bf, 4);
        check("t5_frm0", {16'd0, frm_a[1][bf]},   32'h0401);
        check("t5_frm1", {16'd0, frm_a[1][bf+1]}, 32'h5555);
        check("t5_frm2", {16'd0, frm_a[1][bf+2]}, 32'hAAAA);
        check("t5_frm3", {16'd0, frm_a[1][bf+3]}, 32'hFFFF);
        for (int i = 0; i < 4; i++) begin
            check("t5_csl",  csl_a[1][bf + i], 33);
            check("t5_rise", rise_a[1][bf + i], 16);
        end
        check("t5_ngap", ngap[1] - bg, 3);
        check("t5_gap",  gap_a[1][bg + 2], 2);
        check("t5_busy", bsy_a[1][bb], 140);
        check("t5_nldac_low", ldlow_tot[1], 0);
        check("sck_outside_cs_u0", sck_bad[0], 0);
        check("sck_outside_cs_u1", sck_bad[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
